// File: rtl/rv32_mem_arbiter.sv
// Fetch/data arbiter onto one shared memory port with at most one transaction outstanding.
// Data normally wins; a fetch waiting through STARVE_LIMIT consecutive data wins is then served.
module rv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic [3:0]  d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_GNT = 2'd1, WAIT_RSP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  state_t   state_q, state_d;
  owner_t   owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic     req_q, req_d;
  mem_cmd_t cmd_q, cmd_d;
  logic     perr_q, perr_d;

  logic arb, fire_gnt, fire_rsp;
  logic if_pend, d_pend, if_win, d_win;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    cmd_d    = cmd_q;
    perr_d   = perr_q;
    arb      = 1'b0;
    fire_gnt = 1'b0;
    fire_rsp = 1'b0;

    case (state_q)
      IDLE: begin
        arb = 1'b1;
        if (mem_rvalid_i) perr_d = 1'b1;
      end
      WAIT_GNT: begin
        if (mem_gnt_i) begin
          fire_gnt = 1'b1;
          req_d    = 1'b0;
          state_d  = WAIT_RSP;
          if (mem_rvalid_i) begin
            fire_rsp = 1'b1;
            arb      = 1'b1;
          end
        end else if (mem_rvalid_i) begin
          perr_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          fire_rsp = 1'b1;
          arb      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request being granted this very cycle is the current transaction, not a new one.
    if_pend = if_req_i & ~(fire_gnt & (owner_q == OWN_IF));
    d_pend  = d_req_i  & ~(fire_gnt & (owner_q == OWN_D));
    if_win  = arb & if_pend & (~d_pend | (cnt_q == CNT_MAX));
    d_win   = arb & d_pend & ~if_win;

    if (arb) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      req_d   = 1'b0;
      cnt_d   = '0;
      if (if_win) begin
        state_d     = WAIT_GNT;
        owner_d     = OWN_IF;
        req_d       = 1'b1;
        cmd_d.we    = 4'h0;
        cmd_d.addr  = if_addr_i;
        cmd_d.wdata = 32'h0;
      end else if (d_win) begin
        state_d     = WAIT_GNT;
        owner_d     = OWN_D;
        req_d       = 1'b1;
        cmd_d.we    = d_we_i;
        cmd_d.addr  = d_addr_i;
        cmd_d.wdata = d_wdata_i;
        if (if_pend) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      perr_q  <= perr_d;
    end
  end

  assign if_gnt_o       = fire_gnt & (owner_q == OWN_IF);
  assign d_gnt_o        = fire_gnt & (owner_q == OWN_D);
  assign if_rvalid_o    = fire_rsp & (owner_q == OWN_IF);
  assign d_rvalid_o     = fire_rsp & (owner_q == OWN_D);
  assign if_rdata_o     = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign d_rdata_o      = d_rvalid_o  ? mem_rdata_i : 32'h0;
  assign mem_req_o      = req_q;
  assign mem_we_o       = cmd_q.we;
  assign mem_addr_o     = cmd_q.addr;
  assign mem_wdata_o    = cmd_q.wdata;
  assign protocol_err_o = perr_q;

endmodule
